// File: rtl/updown_game_ctrl_if.sv
// updown_game_ctrl_if: guess-input and hint/status signals between the game controller and its neighbours
interface updown_game_ctrl_if;
  logic       start;
  logic       guess_ready;
  logic [6:0] guess_number;
  logic [1:0] hint;
  logic       hint_valid;
  logic       guess_invalid;
  logic [3:0] tries_used;
  logic [3:0] tries_left;
  logic       game_win;
  logic       game_lose;
  logic       busy;
  logic [2:0] state_out;
  logic [6:0] secret_out;
  modport slave (
    input  start, guess_ready, guess_number,
    output hint, hint_valid, guess_invalid, tries_used, tries_left,
           game_win, game_lose, busy, state_out, secret_out
  );
  modport master (
    output start, guess_ready, guess_number,
    input  hint, hint_valid, guess_invalid, tries_used, tries_left,
           game_win, game_lose, busy, state_out, secret_out
  );
endinterface

// File: rtl/updown_game_ctrl.sv
// updown_game_ctrl: up/down guessing game sequencer; define UPDOWN_REVEAL_SECRET_EN to drive secret_out from the secret
module updown_game_ctrl #(
  parameter int         MAX_TRIES = 7,
  parameter int         NUM_MAX   = 99,
  parameter logic [6:0] LFSR_SEED = 7'h5A
) (
  input logic              clk,
  input logic              reset,
  updown_game_ctrl_if.slave g
);
  localparam logic [2:0] IDLE = 3'd0, GEN = 3'd1, WAIT = 3'd2, COMPARE = 3'd3, WIN = 3'd4, LOSE = 3'd5;
  logic [2:0] state_q, state_d;
  logic [6:0] lfsr_q, lfsr_d, secret_q, secret_d, guess_q, guess_d;
  logic [1:0] hint_q, hint_d;
  logic [3:0] tries_q, tries_d, left_q, left_d;
  logic       hv_q, hv_d, gi_q, gi_d, win_q, win_d, lose_q, lose_d, busy_q, busy_d;
  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    hint_d   = hint_q;
    tries_d  = tries_q;
    hv_d     = 1'b0;
    gi_d     = 1'b0;
    lfsr_d   = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    case (state_q)
      IDLE, WIN, LOSE: if (g.start) begin
        state_d = GEN;
        hint_d  = 2'b00;
        tries_d = 4'd0;
      end
      GEN: if (lfsr_q != 7'd0 && lfsr_q <= 7'(NUM_MAX)) begin
        secret_d = lfsr_q;
        state_d  = WAIT;
      end
      WAIT: if (g.start) begin
        state_d = GEN;
        hint_d  = 2'b00;
        tries_d = 4'd0;
      end else if (g.guess_ready) begin
        guess_d = g.guess_number;
        state_d = COMPARE;
      end
      COMPARE: if (guess_q == 7'd0 || guess_q > 7'(NUM_MAX)) begin
        gi_d    = 1'b1;
        state_d = WAIT;
      end else begin
        hv_d    = 1'b1;
        tries_d = tries_q + 4'd1;
        hint_d  = guess_q == secret_q ? 2'b11 : secret_q > guess_q ? 2'b01 : 2'b10;
        state_d = guess_q == secret_q ? WIN : tries_d == 4'(MAX_TRIES) ? LOSE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    left_d = 4'(MAX_TRIES) - tries_d;
    busy_d = state_d == GEN || state_d == WAIT || state_d == COMPARE;
    win_d  = state_d == WIN;
    lose_d = state_d == LOSE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      secret_q <= 7'd0;
      guess_q  <= 7'd0;
      hint_q   <= 2'b00;
      tries_q  <= 4'd0;
      left_q   <= 4'(MAX_TRIES);
      hv_q     <= 1'b0;
      gi_q     <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      secret_q <= secret_d;
      guess_q  <= guess_d;
      hint_q   <= hint_d;
      tries_q  <= tries_d;
      left_q   <= left_d;
      hv_q     <= hv_d;
      gi_q     <= gi_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      busy_q   <= busy_d;
    end
  end
  assign g.hint          = hint_q;
  assign g.hint_valid    = hv_q;
  assign g.guess_invalid = gi_q;
  assign g.tries_used    = tries_q;
  assign g.tries_left    = left_q;
  assign g.game_win      = win_q;
  assign g.game_lose     = lose_q;
  assign g.busy          = busy_q;
  assign g.state_out     = state_q;
`ifdef UPDOWN_REVEAL_SECRET_EN
  assign g.secret_out = secret_q;
`else
  assign g.secret_out = 7'd0;
`endif
endmodule

// File: tb/tb_updown_game_ctrl.sv
// tb_updown_game_ctrl: directed and randomized game scenarios checked against a game-rule model
module tb_updown_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  updown_game_ctrl_if g();
  updown_game_ctrl dut (.clk(clk), .reset(reset), .g(g));
  int n_cmp = 0, n_bad = 0;
  int exp_state = 0, exp_tries = 0;
  logic [1:0] exp_hint = 2'b00;
  logic [6:0] secret = 7'd0;
  logic [6:0] ref_lfsr;
  // free-running x^7+x^6+1 sequence, used to predict which value the game draws as its secret
  always @(posedge clk or posedge reset)
    ref_lfsr <= reset ? 7'h5A : {ref_lfsr[5:0], ^(ref_lfsr & 7'h60)};

  task automatic check_reset_values(input string tag);
    n_cmp++; if (g.state_out !== 3'd0) begin n_bad++; $display("FAIL %s state: got %0d want 0", tag, g.state_out); end
    n_cmp++; if (g.hint !== 2'b00) begin n_bad++; $display("FAIL %s hint: got %0d want 0", tag, g.hint); end
    n_cmp++; if (g.hint_valid !== 1'b0 || g.guess_invalid !== 1'b0) begin n_bad++; $display("FAIL %s pulses: got hv=%b gi=%b want 0 0", tag, g.hint_valid, g.guess_invalid); end
    n_cmp++; if (g.tries_used !== 4'd0 || g.tries_left !== 4'd7) begin n_bad++; $display("FAIL %s tries: got used=%0d left=%0d want 0 7", tag, g.tries_used, g.tries_left); end
    n_cmp++; if (g.game_win !== 1'b0 || g.game_lose !== 1'b0 || g.busy !== 1'b0) begin n_bad++; $display("FAIL %s flags: got win=%b lose=%b busy=%b want 0 0 0", tag, g.game_win, g.game_lose, g.busy); end
    n_cmp++; if (g.secret_out !== 7'd0) begin n_bad++; $display("FAIL %s secret_out: got %0d want 0", tag, g.secret_out); end
  endtask

  task automatic do_start();
    bit found = 0;
    logic [6:0] v;
    g.start = 1'b1;
    @(negedge clk);
    g.start = 1'b0;
    n_cmp++; if (g.state_out !== 3'd1 || g.busy !== 1'b1) begin n_bad++; $display("FAIL start_gen: got state=%0d busy=%b want 1 1", g.state_out, g.busy); end
    for (int k = 0; k < 130 && !found; k++) begin
      v = ref_lfsr;
      @(negedge clk);
      if (v >= 7'd1 && v <= 7'd99) begin found = 1; secret = v; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL start_secret_search: got none want in-range value"); end
    exp_state = 2; exp_tries = 0; exp_hint = 2'b00;
    n_cmp++; if (g.state_out !== 3'd2 || g.busy !== 1'b1) begin n_bad++; $display("FAIL start_wait: got state=%0d busy=%b want 2 1", g.state_out, g.busy); end
    n_cmp++; if (g.tries_used !== 4'd0 || g.tries_left !== 4'd7 || g.hint !== 2'b00) begin n_bad++; $display("FAIL start_clear: got used=%0d left=%0d hint=%0d want 0 7 0", g.tries_used, g.tries_left, g.hint); end
`ifdef UPDOWN_REVEAL_SECRET_EN
    n_cmp++; if (g.secret_out !== secret) begin n_bad++; $display("FAIL start_secret_out: got %0d want %0d", g.secret_out, secret); end
`else
    n_cmp++; if (g.secret_out !== 7'd0) begin n_bad++; $display("FAIL start_secret_out: got %0d want 0", g.secret_out); end
`endif
  endtask

  task automatic play_guess(input logic [6:0] gn);
    bit legal = gn >= 7'd1 && gn <= 7'd99;
    g.guess_ready = 1'b1;
    g.guess_number = gn;
    @(negedge clk);
    g.guess_ready = 1'b0;
    n_cmp++; if (g.state_out !== 3'd3 || g.hint_valid !== 1'b0) begin n_bad++; $display("FAIL guess_compare: got state=%0d hv=%b want 3 0", g.state_out, g.hint_valid); end
    @(negedge clk);
    if (legal) begin
      exp_tries++;
      exp_hint = gn == secret ? 2'b11 : secret > gn ? 2'b01 : 2'b10;
      exp_state = gn == secret ? 4 : exp_tries == 7 ? 5 : 2;
    end else exp_state = 2;
    n_cmp++; if (g.hint_valid !== legal || g.guess_invalid !== !legal) begin n_bad++; $display("FAIL guess_pulses g=%0d: got hv=%b gi=%b want %b %b", gn, g.hint_valid, g.guess_invalid, legal, !legal); end
    n_cmp++; if (g.hint !== exp_hint) begin n_bad++; $display("FAIL guess_hint g=%0d s=%0d: got %0d want %0d", gn, secret, g.hint, exp_hint); end
    n_cmp++; if (g.tries_used !== 4'(exp_tries) || g.tries_left !== 4'(7 - exp_tries)) begin n_bad++; $display("FAIL guess_tries: got used=%0d left=%0d want %0d %0d", g.tries_used, g.tries_left, exp_tries, 7 - exp_tries); end
    n_cmp++; if (g.state_out !== 3'(exp_state)) begin n_bad++; $display("FAIL guess_state: got %0d want %0d", g.state_out, exp_state); end
    n_cmp++; if (g.game_win !== (exp_state == 4) || g.game_lose !== (exp_state == 5) || g.busy !== (exp_state == 2)) begin n_bad++; $display("FAIL guess_flags: got win=%b lose=%b busy=%b want state %0d", g.game_win, g.game_lose, g.busy, exp_state); end
    @(negedge clk);
    n_cmp++; if (g.hint_valid !== 1'b0 || g.guess_invalid !== 1'b0) begin n_bad++; $display("FAIL guess_pulse_width: got hv=%b gi=%b want 0 0", g.hint_valid, g.guess_invalid); end
  endtask

  task automatic drop_guess(input string tag);
    bit seen = 0;
    g.guess_ready = 1'b1;
    g.guess_number = 7'($urandom_range(1, 99));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g.guess_ready = 1'b0;
      if (g.hint_valid || g.guess_invalid) seen = 1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL %s dropped_guess: got pulse=1 want 0", tag); end
    n_cmp++; if (g.state_out !== 3'(exp_state) || g.tries_used !== 4'(exp_tries) || g.hint !== exp_hint) begin n_bad++; $display("FAIL %s dropped_hold: got state=%0d used=%0d hint=%0d want %0d %0d %0d", tag, g.state_out, g.tries_used, g.hint, exp_state, exp_tries, exp_hint); end
  endtask

  task automatic test_reset();
    g.start = 1'b0; g.guess_ready = 1'b0; g.guess_number = 7'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_asserted");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_values("reset_idle");
    drop_guess("idle");
  endtask

  task automatic test_win();
    do_start();
    if (secret > 7'd1) play_guess(secret - 7'd1);
    if (secret < 7'd99) play_guess(secret + 7'd1);
    play_guess(secret);
    drop_guess("win");
  endtask

  task automatic test_lose();
    logic [6:0] w;
    do_start();
    w = secret < 7'd99 ? secret + 7'd1 : secret - 7'd1;
    repeat (7) play_guess(w);
    n_cmp++; if (g.game_lose !== 1'b1 || g.tries_left !== 4'd0) begin n_bad++; $display("FAIL lose_final: got lose=%b left=%0d want 1 0", g.game_lose, g.tries_left); end
    drop_guess("lose");
  endtask

  task automatic test_invalid();
    do_start();
    play_guess(7'd0);
    play_guess(7'd100);
    play_guess(7'd127);
    play_guess(secret == 7'd50 ? 7'd51 : 7'd50);
  endtask

  task automatic test_abort();
    do_start();
    for (int k = 0; k < 3; k++) play_guess(secret == 7'(k + 1) ? 7'(k + 10) : 7'(k + 1));
    do_start();
    play_guess(secret);
  endtask

  task automatic test_reset_in_compare();
    do_start();
    g.guess_ready = 1'b1;
    g.guess_number = secret;
    @(negedge clk);
    g.guess_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_values("reset_compare");
    @(negedge clk);
    reset = 1'b0;
    exp_state = 0; exp_tries = 0; exp_hint = 2'b00;
    drop_guess("after_reset");
    check_reset_values("after_reset");
    do_start();
    play_guess(secret);
  endtask

  task automatic test_random();
    for (int gm = 0; gm < 10; gm++) begin
      do_start();
      for (int it = 0; it < 40 && exp_state == 2; it++) begin
        int r = $urandom_range(0, 19);
        if (r == 0 && gm[0]) do_start();
        else if (r == 1) play_guess($urandom_range(0, 1) ? 7'd0 : 7'($urandom_range(100, 127)));
        else if (r == 2) play_guess(secret);
        else play_guess(7'($urandom_range(1, 99)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_lose();
    test_invalid();
    test_abort();
    test_reset_in_compare();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
